// File: rtl/miner_nonce_sequencer.sv
// rtl/miner_nonce_sequencer.sv - walks the hash core across a nonce range, stopping on hit/exhaust/timeout/abort
module miner_nonce_sequencer #(
    parameter int NONCE_W = 32,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_start,
    input  logic               cfg_abort,
    input  logic [NONCE_W-1:0] cfg_nonce_first,
    input  logic [NONCE_W-1:0] cfg_nonce_last,
    output logic               core_start,
    output logic [NONCE_W-1:0] core_nonce,
    input  logic               core_done,
    input  logic               core_hit,
    output logic               bsy,
    output logic               done_pulse,
    output logic               found,
    output logic [NONCE_W-1:0] found_nonce,
    output logic               exhausted,
    output logic               timeout_err,
    output logic               aborted,
    output logic [NONCE_W:0]   nonce_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);
    localparam bit              WD_EN   = (TIMEOUT != 0);

    state_t               state_q, state_d;
    logic [NONCE_W-1:0]   last_q, last_d;
    logic [NONCE_W-1:0]   cur_q, cur_d;
    logic [TO_W-1:0]      wd_q, wd_d;
    logic                 core_start_q, core_start_d;
    logic [NONCE_W-1:0]   core_nonce_q, core_nonce_d;
    logic                 bsy_q, bsy_d;
    logic                 done_pulse_q, done_pulse_d;
    logic                 found_q, found_d;
    logic [NONCE_W-1:0]   found_nonce_q, found_nonce_d;
    logic                 exhausted_q, exhausted_d;
    logic                 timeout_q, timeout_d;
    logic                 aborted_q, aborted_d;
    logic [NONCE_W:0]     count_q, count_d;
    logic                 wd_expire;

    // The watchdog is cleared while the nonce is issued and counts every cycle after.
    assign wd_expire = WD_EN && (wd_q == WD_LAST);

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        cur_d         = cur_q;
        wd_d          = wd_q;
        core_nonce_d  = core_nonce_q;
        found_d       = found_q;
        found_nonce_d = found_nonce_q;
        exhausted_d   = exhausted_q;
        timeout_d     = timeout_q;
        aborted_d     = aborted_q;
        count_d       = count_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    last_d      = cfg_nonce_last;
                    cur_d       = cfg_nonce_first;
                    found_d     = 1'b0;
                    exhausted_d = 1'b0;
                    timeout_d   = 1'b0;
                    aborted_d   = 1'b0;
                    count_d     = '0;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_d = wd_q + TO_W'(1);
                if (cfg_abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wd_d = wd_q + TO_W'(1);
                if (cfg_abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (core_done) begin
                    count_d = count_q + (NONCE_W+1)'(1);
                    if (core_hit) begin
                        found_d       = 1'b1;
                        found_nonce_d = cur_q;
                        state_d       = ST_DONE;
                    end else if (cur_q == last_q) begin
                        exhausted_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        cur_d   = cur_q + NONCE_W'(1);
                        state_d = ST_ISSUE;
                    end
                end else if (wd_expire) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (cfg_abort) aborted_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_ISSUE) begin
            wd_d         = '0;
            core_nonce_d = cur_d;
        end
        core_start_d = (state_d == ST_ISSUE);
        done_pulse_d = (state_d == ST_DONE);
        bsy_d        = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            last_q        <= '0;
            cur_q         <= '0;
            wd_q          <= '0;
            core_start_q  <= 1'b0;
            core_nonce_q  <= '0;
            bsy_q         <= 1'b0;
            done_pulse_q  <= 1'b0;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            exhausted_q   <= 1'b0;
            timeout_q     <= 1'b0;
            aborted_q     <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            cur_q         <= cur_d;
            wd_q          <= wd_d;
            core_start_q  <= core_start_d;
            core_nonce_q  <= core_nonce_d;
            bsy_q         <= bsy_d;
            done_pulse_q  <= done_pulse_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
            exhausted_q   <= exhausted_d;
            timeout_q     <= timeout_d;
            aborted_q     <= aborted_d;
            count_q       <= count_d;
        end
    end

    assign core_start  = core_start_q;
    assign core_nonce  = core_nonce_q;
    assign bsy         = bsy_q;
    assign done_pulse  = done_pulse_q;
    assign found       = found_q;
    assign found_nonce = found_nonce_q;
    assign exhausted   = exhausted_q;
    assign timeout_err = timeout_q;
    assign aborted     = aborted_q;
    assign nonce_count = count_q;

endmodule

// File: tb/tb_miner_nonce_sequencer.sv
// tb/tb_miner_nonce_sequencer.sv - directed self-checking bench for miner_nonce_sequencer
module tb_miner_nonce_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_start, cfg_abort;
    logic [31:0] cfg_nonce_first, cfg_nonce_last;
    logic        core_start;
    logic [31:0] core_nonce;
    logic        core_done, core_hit;
    logic        bsy, done_pulse, found, exhausted, timeout_err, aborted;
    logic [31:0] found_nonce;
    logic [32:0] nonce_count;

    int          passed = 0;
    int          total  = 0;
    int          done_cnt = 0;
    int          core_lat = 5;
    int          lat_cnt = 0;
    bit          core_silent = 0;
    bit          hit_en = 0;
    bit          rand_in = 0;
    bit          pend = 0;
    logic [31:0] hit_nonce = '0;
    logic [31:0] pend_nonce = '0;
    logic [31:0] issued[$];
    logic [31:0] exp_q[$];

    wire [103:0] all_outs = {core_start, core_nonce, bsy, done_pulse, found, found_nonce,
                             exhausted, timeout_err, aborted, nonce_count};

    miner_nonce_sequencer #(.NONCE_W(32), .TIMEOUT(8), .TO_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_nonce_first(cfg_nonce_first), .cfg_nonce_last(cfg_nonce_last),
        .core_start(core_start), .core_nonce(core_nonce),
        .core_done(core_done), .core_hit(core_hit),
        .bsy(bsy), .done_pulse(done_pulse), .found(found), .found_nonce(found_nonce),
        .exhausted(exhausted), .timeout_err(timeout_err), .aborted(aborted),
        .nonce_count(nonce_count)
    );

    always #5 clk = ~clk;

    // Hash core stand-in: answers core_lat cycles after each core_start.
    always @(negedge clk) begin
        core_done = 1'b0;
        core_hit  = 1'b0;
        if (!reset_n) begin
            pend = 0;
            if (rand_in) begin
                core_done = 1'($urandom);
                core_hit  = 1'($urandom);
            end
        end else begin
            if (pend) begin
                lat_cnt++;
                if (lat_cnt == core_lat) begin
                    pend = 0;
                    if (!core_silent) begin
                        core_done = 1'b1;
                        core_hit  = hit_en && (pend_nonce == hit_nonce);
                    end
                end
            end
            if (core_start) begin
                pend       = 1;
                lat_cnt    = 0;
                pend_nonce = core_nonce;
                issued.push_back(core_nonce);
            end
        end
        if (done_pulse) done_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic start_run(input logic [31:0] first, input logic [31:0] last, input bit with_abort);
        cfg_nonce_first = first;
        cfg_nonce_last  = last;
        cfg_start       = 1'b1;
        cfg_abort       = with_abort;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done_pulse) begin
                seen = 1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 128'(seen), 128'(1));
    endtask

    task automatic check_issued(input string tag);
        chk({tag, "_issue_cnt"}, 128'(issued.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < issued.size(); i++)
            chk($sformatf("%s_issue%0d", tag, i), 128'(issued[i]), 128'(exp_q[i]));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        cfg_start = 0; cfg_abort = 0; cfg_nonce_first = '0; cfg_nonce_last = '0;
        rand_in = 1;
        repeat (4) begin
            @(negedge clk);
            cfg_start = 1'($urandom); cfg_abort = 1'($urandom);
            cfg_nonce_first = $urandom; cfg_nonce_last = $urandom;
        end
        @(negedge clk);
        chk("reset_outputs", 128'(all_outs), 128'(0));
        cfg_start = 0; cfg_abort = 0; rand_in = 0;
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", 128'(all_outs), 128'(0));

        // Exhaust 0x10..0x13, no hit
        issued.delete(); done_cnt = 0;
        start_run(32'h10, 32'h13, 0);
        chk("lat_core_start", 128'(core_start), 128'(1));
        chk("lat_core_nonce", 128'(core_nonce), 128'(32'h10));
        chk("lat_bsy", 128'(bsy), 128'(1));
        wait_done("exh");
        chk("exh_exhausted", 128'(exhausted), 128'(1));
        chk("exh_found", 128'(found), 128'(0));
        chk("exh_count", 128'(nonce_count), 128'(4));
        chk("exh_bsy_in_done", 128'(bsy), 128'(1));
        @(negedge clk);
        chk("exh_bsy_after", 128'(bsy), 128'(0));
        chk("exh_done_cnt", 128'(done_cnt), 128'(1));
        exp_q = '{32'h10, 32'h11, 32'h12, 32'h13};
        check_issued("exh");

        // Abort in idle is ignored
        cfg_abort = 1;
        @(negedge clk);
        cfg_abort = 0;
        @(negedge clk);
        chk("idle_abort_flag", 128'(aborted), 128'(0));
        chk("idle_abort_bsy", 128'(bsy), 128'(0));
        chk("idle_abort_exh_kept", 128'(exhausted), 128'(1));

        // Hit on 0x105
        issued.delete(); hit_en = 1; hit_nonce = 32'h105;
        start_run(32'h100, 32'h1FF, 0);
        wait_done("hit");
        chk("hit_found", 128'(found), 128'(1));
        chk("hit_found_nonce", 128'(found_nonce), 128'(32'h105));
        chk("hit_count", 128'(nonce_count), 128'(6));
        chk("hit_exhausted", 128'(exhausted), 128'(0));
        repeat (10) @(negedge clk);
        exp_q = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105};
        check_issued("hit");
        hit_en = 0;

        // Wrap, with a simultaneous abort in the start cycle
        issued.delete();
        start_run(32'hFFFF_FFFE, 32'h0000_0001, 1);
        wait_done("wrap");
        chk("wrap_count", 128'(nonce_count), 128'(4));
        chk("wrap_exhausted", 128'(exhausted), 128'(1));
        chk("wrap_aborted", 128'(aborted), 128'(0));
        chk("wrap_found_cleared", 128'(found), 128'(0));
        @(negedge clk);
        exp_q = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        check_issued("wrap");

        // Watchdog expiry: core silent
        issued.delete(); core_silent = 1;
        start_run(32'h60, 32'h70, 0);
        repeat (7) @(negedge clk);
        chk("wd_not_yet", 128'(timeout_err), 128'(0));
        @(negedge clk);
        chk("wd_timeout", 128'(timeout_err), 128'(1));
        chk("wd_done_pulse", 128'(done_pulse), 128'(1));
        chk("wd_count", 128'(nonce_count), 128'(0));
        @(negedge clk);
        core_silent = 0;
        repeat (3) @(negedge clk);

        // core_done lands in the expiry cycle; single-nonce range
        issued.delete(); core_lat = 7;
        start_run(32'h50, 32'h50, 0);
        repeat (8) @(negedge clk);
        chk("wdx_timeout", 128'(timeout_err), 128'(0));
        chk("wdx_exhausted", 128'(exhausted), 128'(1));
        chk("wdx_count", 128'(nonce_count), 128'(1));
        chk("wdx_done_pulse", 128'(done_pulse), 128'(1));
        @(negedge clk);
        chk("wdx_issue_cnt1", 128'(issued.size()), 128'(1));
        core_lat = 5;

        // Abort races a hit result
        issued.delete(); hit_en = 1; hit_nonce = 32'h200;
        start_run(32'h200, 32'h20F, 0);
        repeat (5) @(negedge clk);
        cfg_abort = 1;
        @(negedge clk);
        cfg_abort = 0;
        chk("race_done_pulse", 128'(done_pulse), 128'(1));
        chk("race_aborted", 128'(aborted), 128'(1));
        chk("race_found", 128'(found), 128'(0));
        chk("race_count", 128'(nonce_count), 128'(0));
        @(negedge clk);
        chk("race_bsy_after", 128'(bsy), 128'(0));
        hit_en = 0;

        // cfg_start while busy is ignored
        issued.delete();
        start_run(32'h300, 32'h302, 0);
        repeat (2) @(negedge clk);
        start_run(32'h0, 32'h0, 0);
        wait_done("busy_start");
        chk("busy_start_count", 128'(nonce_count), 128'(3));
        chk("busy_start_aborted", 128'(aborted), 128'(0));
        @(negedge clk);
        exp_q = '{32'h300, 32'h301, 32'h302};
        check_issued("busy_start");

        // Asynchronous reset mid-WAIT
        start_run(32'h40, 32'h4F, 0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b0;
        #1 chk("async_reset_outputs", 128'(all_outs), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        issued.delete();
        start_run(32'h40, 32'h41, 0);
        wait_done("post_reset");
        chk("post_reset_count", 128'(nonce_count), 128'(2));
        chk("post_reset_exhausted", 128'(exhausted), 128'(1));
        @(negedge clk);
        exp_q = '{32'h40, 32'h41};
        check_issued("post_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
